// File: rtl/samcoupe_pkg.sv
`default_nettype none
// ------------------------------------------------------------
// samcoupe_pkg : shared CPU clock-enable types and constants
// rev 1.0
// ------------------------------------------------------------
package samcoupe_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_QUIET = 2'd2
  } ce_state_e;

  localparam int STALL_W = 16;

  function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
    return (&v) ? v : v + STALL_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ce_divider.sv
`default_nettype none
// ------------------------------------------------------------
// ce_divider : divide-by-D counter producing gated ce_p / ce_n
// rev 1.0
// ------------------------------------------------------------
module ce_divider #(
  parameter int DIVW = 6
) (
  input  logic            clk_sys,
  input  logic            reset,
  input  logic [DIVW-1:0] divisor,
  input  logic            run,
  input  logic            wait_req,
  output logic            ce_p,
  output logic            ce_n,
  output logic            period_end,
  output logic            stalled
);

  logic [DIVW-1:0] cnt;
  logic [DIVW-1:0] half;
  logic            gate;
  logic            at_start;
  logic            at_half;
  logic            at_last;

  assign half     = divisor >> 1;
  assign at_start = (cnt == '0);
  assign at_half  = (cnt == half);
  // >= rather than == keeps the counter bounded even if divisor ever shrinks
  assign at_last  = (cnt >= divisor - DIVW'(1));

  assign period_end = run & at_last;
  assign stalled    = run & at_start & wait_req;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      gate <= 1'b0;
      ce_p <= 1'b0;
      ce_n <= 1'b0;
    end else if (!run) begin
      cnt  <= '0;
      gate <= 1'b0;
      ce_p <= 1'b0;
      ce_n <= 1'b0;
    end else begin
      cnt  <= at_last ? '0 : cnt + DIVW'(1);
      if (at_start) begin
        gate <= ~wait_req;
      end
      ce_p <= at_start & ~wait_req;
      ce_n <= at_half & gate & ~at_start;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cpu_ce_gen.sv
`default_nettype none
// ------------------------------------------------------------
// cpu_ce_gen : multi-speed CPU clock-enable generator with quiet mode switch
// rev 1.0
// ------------------------------------------------------------
module cpu_ce_gen
  import samcoupe_pkg::*;
#(
  parameter int                    MODES     = 4,
  parameter int                    DIVW      = 6,
  parameter logic [MODES*DIVW-1:0] DIV_TABLE = {6'd4, 6'd8, 6'd27, 6'd16},
  parameter int                    QUIET_CYC = 32
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  input  logic [$clog2(MODES)-1:0] req_mode,
  input  logic                     wait_req,
  input  logic                     stat_clr,
  output logic                     ce_p,
  output logic                     ce_n,
  output logic [$clog2(MODES)-1:0] cur_mode,
  output logic                     switching,
  output logic [STALL_W-1:0]       stall_cnt
);

  localparam int             MW     = $clog2(MODES);
  localparam int             QW     = $clog2(QUIET_CYC + 1);
  localparam logic [QW-1:0]  Q_LAST = QW'(QUIET_CYC - 1);

  ce_state_e       state;
  ce_state_e       state_nx;
  logic [QW-1:0]   qcnt;
  logic [QW-1:0]   qcnt_nx;
  logic [MW-1:0]   mode_nx;
  logic [DIVW-1:0] div_arr [MODES];
  logic [DIVW-1:0] divisor;
  logic            req_ok;
  logic            run;
  logic            period_end;
  logic            stalled;

  // entries of 0 or 1 would stall the divider, so they are forced to 2
  for (genvar i = 0; i < MODES; i++) begin : g_div
    assign div_arr[i] = (DIV_TABLE[i*DIVW +: DIVW] < DIVW'(2)) ? DIVW'(2)
                                                              : DIV_TABLE[i*DIVW +: DIVW];
  end

  always_comb begin
    divisor = div_arr[0];
    req_ok  = 1'b0;
    for (int i = 0; i < MODES; i++) begin
      if (cur_mode == MW'(i)) divisor = div_arr[i];
      if (req_mode == MW'(i)) req_ok = 1'b1;
    end
  end

  assign run       = (state != ST_QUIET);
  assign switching = (state != ST_RUN);

  ce_divider #(
    .DIVW (DIVW)
  ) u_div (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .divisor    (divisor),
    .run        (run),
    .wait_req   (wait_req),
    .ce_p       (ce_p),
    .ce_n       (ce_n),
    .period_end (period_end),
    .stalled    (stalled)
  );

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state    <= ST_RUN;
      cur_mode <= '0;
      qcnt     <= '0;
    end else begin
      state    <= state_nx;
      cur_mode <= mode_nx;
      qcnt     <= qcnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    qcnt_nx  = qcnt;
    mode_nx  = cur_mode;
    case (state)
      ST_RUN: begin
        if (req_ok && (req_mode != cur_mode)) state_nx = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (period_end) begin
          state_nx = ST_QUIET;
          qcnt_nx  = '0;
        end
      end
      ST_QUIET: begin
        // the new mode is whatever is requested on the final quiet cycle
        if (qcnt == Q_LAST) begin
          state_nx = ST_RUN;
          if (req_ok) mode_nx = req_mode;
        end else begin
          qcnt_nx = qcnt + QW'(1);
        end
      end
      default: state_nx = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stat_clr) begin
      stall_cnt <= '0;
    end else if (stalled) begin
      stall_cnt <= sat_inc(stall_cnt);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_ce_gen.sv
`default_nettype none
// ------------------------------------------------------------
// tb_cpu_ce_gen : directed + randomized bench with behavioural model
// rev 1.0
// ------------------------------------------------------------
module tb_cpu_ce_gen;

  localparam int QUIET = 32;

  logic        clk_sys  = 1'b0;
  logic        reset    = 1'b1;
  logic [1:0]  req_mode = 2'd0;
  logic        wait_req = 1'b0;
  logic        stat_clr = 1'b0;
  logic        ce_p;
  logic        ce_n;
  logic [1:0]  cur_mode;
  logic        switching;
  logic [15:0] stall_cnt;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // clk_sys periods per CPU clock, indexed by mode
  int div_tbl [4] = '{16, 27, 8, 4};

  int m_mode, m_pos, m_quiet, m_drain, m_gate, m_p, m_n, m_stall;

  always #5 clk_sys = ~clk_sys;

  cpu_ce_gen dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .req_mode  (req_mode),
    .wait_req  (wait_req),
    .stat_clr  (stat_clr),
    .ce_p      (ce_p),
    .ce_n      (ce_n),
    .cur_mode  (cur_mode),
    .switching (switching),
    .stall_cnt (stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_pos = 0; m_quiet = 0; m_drain = 0;
    m_gate = 0; m_p = 0; m_n = 0; m_stall = 0;
  endtask

  // One clk_sys period of the CPU clock rules: pulses per period, drain, quiet gap.
  task automatic model_edge(input int rm, input bit w, input bit clr);
    int d;
    bit st;
    d   = div_tbl[m_mode];
    m_p = 0;
    m_n = 0;
    st  = 0;
    if (m_quiet > 0) begin
      if (m_quiet == 1) begin
        m_mode  = rm;
        m_pos   = 0;
        m_quiet = 0;
      end else begin
        m_quiet--;
      end
    end else begin
      if (m_pos == 0) begin
        m_gate = w ? 0 : 1;
        m_p    = m_gate;
        st     = w;
      end
      if (m_pos == d / 2 && m_gate == 1) m_n = 1;
      if (m_drain == 1 && m_pos == d - 1) begin
        m_drain = 0;
        m_quiet = QUIET;
      end else if (m_drain == 0 && rm != m_mode) begin
        m_drain = 1;
      end
      m_pos = (m_pos + 1) % d;
    end
    if (clr) m_stall = 0;
    else if (st && m_stall < 65535) m_stall++;
  endtask

  task automatic step();
    @(posedge clk_sys);
    if (reset) model_reset();
    else model_edge(int'(req_mode), wait_req, stat_clr);
    @(negedge clk_sys);
    cyc++;
    check("ce_p", 32'(ce_p), 32'(m_p));
    check("ce_n", 32'(ce_n), 32'(m_n));
    check("cur_mode", 32'(cur_mode), 32'(m_mode));
    check("switching", 32'(switching), 32'((m_drain == 1 || m_quiet > 0) ? 1 : 0));
    check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
    check("p_n_excl", 32'(ce_p & ce_n), 32'd0);
  endtask

  task automatic wait_switch(input int budget);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while ((switching || n < 2) && n < budget);
    check("switch_done", 32'(switching), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int np, nn, lp, cnt_sw, cnt_n_sw, cnt_p_sw;
    model_reset();
    repeat (3) step();
    check("rst_ce_p", 32'(ce_p), 32'd0);
    check("rst_ce_n", 32'(ce_n), 32'd0);
    check("rst_mode", 32'(cur_mode), 32'd0);
    check("rst_sw", 32'(switching), 32'd0);
    check("rst_stall", 32'(stall_cnt), 32'd0);

    // mode 0: ten periods of 16
    reset = 1'b0;
    np = 0; nn = 0; lp = -100;
    for (int i = 0; i < 160; i++) begin
      step();
      if (i == 0) check("first_ce_p", 32'(ce_p), 32'd1);
      if (ce_p) begin np++; lp = cyc; end
      if (ce_n) begin nn++; check("m0_n_lag", 32'(cyc - lp), 32'd8); end
    end
    check("m0_p_count", 32'(np), 32'd10);
    check("m0_n_count", 32'(nn), 32'd10);

    // three stalled periods
    stat_clr = 1'b1; step(); stat_clr = 1'b0;
    check("stall_clr0", 32'(stall_cnt), 32'd0);
    wait_req = 1'b1;
    np = 0;
    for (int i = 0; i < 48; i++) begin
      step();
      if (ce_p) np++;
    end
    wait_req = 1'b0;
    step();
    check("stall3", 32'(stall_cnt), 32'd3);
    check("stall_no_p", 32'(np), 32'd0);
    stat_clr = 1'b1; step(); stat_clr = 1'b0;
    check("stall_clr", 32'(stall_cnt), 32'd0);

    // divisor 27
    req_mode = 2'd1;
    wait_switch(200);
    check("d27_mode", 32'(cur_mode), 32'd1);
    np = 0; lp = -1;
    for (int i = 0; i < 27 * 100 + 30; i++) begin
      step();
      if (ce_p) begin
        if (lp >= 0) check("d27_period", 32'(cyc - lp), 32'd27);
        lp = cyc;
        np++;
      end
      if (ce_n) check("d27_lag", 32'(cyc - lp), 32'd13);
    end
    check("d27_count", 32'(np >= 100), 32'd1);

    // back to mode 0, then 0->3 early in a period
    req_mode = 2'd0;
    wait_switch(200);
    repeat (3) step();
    req_mode = 2'd3;
    cnt_sw = 0; cnt_n_sw = 0; cnt_p_sw = 0;
    step();
    while (switching && cnt_sw < 200) begin
      cnt_sw++;
      if (ce_n) cnt_n_sw++;
      if (ce_p) cnt_p_sw++;
      step();
    end
    check("sw03_cycles", 32'(cnt_sw), 32'd44);
    check("sw03_drain_n", 32'(cnt_n_sw), 32'd1);
    check("sw03_no_p", 32'(cnt_p_sw), 32'd0);
    check("sw03_mode", 32'(cur_mode), 32'd3);
    step();
    check("sw03_first_p", 32'(ce_p), 32'd1);
    lp = cyc;
    for (int i = 0; i < 32; i++) begin
      step();
      if (ce_p) begin check("m3_period", 32'(cyc - lp), 32'd4); lp = cyc; end
      if (ce_n) check("m3_lag", 32'(cyc - lp), 32'd2);
    end

    // 0 -> 1 -> 0 while quiet: mode must stay 0
    req_mode = 2'd0;
    wait_switch(200);
    req_mode = 2'd1;
    for (int i = 0; i < 200 && m_quiet == 0; i++) step();
    repeat (5) step();
    req_mode = 2'd0;
    np = 0;
    wait_switch(200);
    check("q010_mode", 32'(cur_mode), 32'd0);
    for (int i = 0; i < 32; i++) begin
      step();
      if (ce_p) np++;
    end
    check("q010_p", 32'(np), 32'd2);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      wait_req = ($urandom_range(0, 3) == 0);
      stat_clr = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 199) == 0) req_mode = 2'($urandom_range(0, 3));
      step();
    end
    wait_req = 1'b0;
    stat_clr = 1'b0;

    // reset in the middle of a quiet gap
    req_mode = cur_mode + 2'd1;
    for (int i = 0; i < 300 && !(m_quiet > 0 && m_quiet < QUIET - 3); i++) step();
    check("rq_in_quiet", 32'(m_quiet > 0), 32'd1);
    reset = 1'b1;
    #1;
    check("rq_ce_p", 32'(ce_p), 32'd0);
    check("rq_ce_n", 32'(ce_n), 32'd0);
    check("rq_mode", 32'(cur_mode), 32'd0);
    check("rq_sw", 32'(switching), 32'd0);
    check("rq_stall", 32'(stall_cnt), 32'd0);
    model_reset();
    req_mode = 2'd0;
    repeat (2) step();
    reset = 1'b0;
    step();
    check("rq_first_p", 32'(ce_p), 32'd1);
    repeat (40) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
